axi_write_ctrl: RTL and testbench



---
 rtl/axi_write_ctrl.sv | 117 +++++++++++
 tb/tb_axi_write_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/axi_write_ctrl.sv
// Write-channel controller for a 1-master / 6-slave AXI4-Lite interconnect.
// Decodes AWADDR into a stable demux select and completes unmapped addresses locally with DECERR.
module axi_write_ctrl #(
    parameter int ADDR    = 32,
    parameter int RESP    = 2,
    parameter int SEL_LSB = 12
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR-1:0]   M00_AWADDR,
    input  logic              M00_AWVALID,
    output logic              M00_AWREADY,
    input  logic              M00_WVALID,
    output logic              M00_WREADY,
    output logic              M00_BVALID,
    output logic [RESP-1:0]   M00_BRESP,
    input  logic              M00_BREADY,
    output logic [2:0]        sel,
    output logic              AWVALID_G,
    output logic              WVALID_G,
    output logic              BREADY_G,
    input  logic [5:0]        S_AWREADY,
    input  logic [5:0]        S_WREADY,
    input  logic [5:0]        S_BVALID,
    input  logic [6*RESP-1:0] S_BRESP,
    output logic              busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_EADDR = 3'd4;
    localparam logic [2:0] ST_EDATA = 3'd5;
    localparam logic [2:0] ST_ERESP = 3'd6;

    localparam logic [RESP-1:0] DECERR = '1;

    logic [2:0]      state, state_nxt;
    logic [2:0]      idx;
    logic            idx_ok;
    logic [RESP-1:0] slv_resp;
    logic            addr_unused;

    assign idx         = M00_AWADDR[SEL_LSB+2:SEL_LSB];
    assign idx_ok      = (idx <= 3'd5);
    assign slv_resp    = S_BRESP[int'(sel)*RESP +: RESP];
    assign addr_unused = ^{M00_AWADDR[ADDR-1:SEL_LSB+3], M00_AWADDR[SEL_LSB-1:0]};
    assign busy        = (state != ST_IDLE);

    // sel only loads on IDLE->ADDR, so the demux path cannot move mid-transaction
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= ST_IDLE;
            sel   <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && M00_AWVALID && idx_ok)
                sel <= idx;
        end
    end

    always_comb begin
        state_nxt   = state;
        M00_AWREADY = 1'b0;
        M00_WREADY  = 1'b0;
        M00_BVALID  = 1'b0;
        M00_BRESP   = '0;
        AWVALID_G   = 1'b0;
        WVALID_G    = 1'b0;
        BREADY_G    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (M00_AWVALID)
                    state_nxt = idx_ok ? ST_ADDR : ST_EADDR;
            end
            ST_ADDR: begin
                AWVALID_G   = M00_AWVALID;
                M00_AWREADY = S_AWREADY[sel];
                if (M00_AWVALID && S_AWREADY[sel])
                    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                WVALID_G   = M00_WVALID;
                M00_WREADY = S_WREADY[sel];
                if (M00_WVALID && S_WREADY[sel])
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                BREADY_G   = M00_BREADY;
                M00_BVALID = S_BVALID[sel];
                // response code is only meaningful alongside BVALID
                if (S_BVALID[sel])
                    M00_BRESP = slv_resp;
                if (S_BVALID[sel] && M00_BREADY)
                    state_nxt = ST_IDLE;
            end
            ST_EADDR: begin
                M00_AWREADY = 1'b1;
                state_nxt   = ST_EDATA;
            end
            ST_EDATA: begin
                M00_WREADY = 1'b1;
                if (M00_WVALID)
                    state_nxt = ST_ERESP;
            end
            ST_ERESP: begin
                M00_BVALID = 1'b1;
                M00_BRESP  = DECERR;
                if (M00_BREADY)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_write_ctrl.sv
// Directed bench for axi_write_ctrl: mapped, stalled, DECERR, early-W, back-to-back and reset cases.
module tb_axi_write_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] M00_AWADDR;
    logic        M00_AWVALID, M00_AWREADY;
    logic        M00_WVALID, M00_WREADY;
    logic        M00_BVALID, M00_BREADY;
    logic [1:0]  M00_BRESP;
    logic [2:0]  sel;
    logic        AWVALID_G, WVALID_G, BREADY_G, busy;
    logic [5:0]  S_AWREADY, S_WREADY, S_BVALID;
    logic [11:0] S_BRESP;

    int n_cmp = 0;
    int n_err = 0;
    int whs   = 0;
    int whs0;

    axi_write_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M00_AWADDR(M00_AWADDR), .M00_AWVALID(M00_AWVALID), .M00_AWREADY(M00_AWREADY),
        .M00_WVALID(M00_WVALID), .M00_WREADY(M00_WREADY),
        .M00_BVALID(M00_BVALID), .M00_BRESP(M00_BRESP), .M00_BREADY(M00_BREADY),
        .sel(sel), .AWVALID_G(AWVALID_G), .WVALID_G(WVALID_G), .BREADY_G(BREADY_G),
        .S_AWREADY(S_AWREADY), .S_WREADY(S_WREADY), .S_BVALID(S_BVALID), .S_BRESP(S_BRESP),
        .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK)
        if (M00_WVALID && M00_WREADY) whs <= whs + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // packed as {awready,wready,bvalid,bresp,awvalid_g,wvalid_g,bready_g,sel,busy}
    task automatic exp_out(input string tag, input logic awr, input logic wr, input logic bv,
                           input logic [1:0] br, input logic awg, input logic wg, input logic bg,
                           input logic [2:0] s, input logic bz);
        #1;
        chk(tag, {20'd0, M00_AWREADY, M00_WREADY, M00_BVALID, M00_BRESP,
                  AWVALID_G, WVALID_G, BREADY_G, sel, busy},
                 {20'd0, awr, wr, bv, br, awg, wg, bg, s, bz});
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESET = 1'b1;
        M00_AWADDR = '0; M00_AWVALID = 1'b0; M00_WVALID = 1'b0; M00_BREADY = 1'b0;
        S_AWREADY = '0; S_WREADY = '0; S_BVALID = '0;
        // slot5..slot0 = 10,01,01,00,10,00
        S_BRESP = {2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        exp_out("reset", 0,0,0,2'b00,0,0,0,3'd0,0);

        // idx 3, all slaves ready
        S_AWREADY = '1; S_WREADY = '1; S_BVALID = '1;
        M00_AWADDR = 32'h0000_3004; M00_AWVALID = 1'b1; M00_BREADY = 1'b1;
        exp_out("t1_idle", 0,0,0,2'b00,0,0,0,3'd0,0);
        cyc();                                        exp_out("t1_addr", 1,0,0,2'b00,1,0,0,3'd3,1);
        cyc(); M00_AWVALID = 1'b0; M00_WVALID = 1'b1; exp_out("t1_data", 0,1,0,2'b00,0,1,0,3'd3,1);
        cyc(); M00_WVALID = 1'b0;                     exp_out("t1_resp", 0,0,1,2'b01,0,0,1,3'd3,1);
        cyc();                                        exp_out("t1_done", 0,0,0,2'b00,0,0,0,3'd3,0);

        // idx 5: AWREADY low 4 cycles, BVALID 2 cycles late with SLVERR
        S_AWREADY = 6'h1f; S_BVALID = 6'h1f;
        M00_AWADDR = 32'h0000_5000; M00_AWVALID = 1'b1;
        exp_out("t2_idle", 0,0,0,2'b00,0,0,0,3'd3,0);
        for (int i = 0; i < 4; i++) begin
            cyc(); exp_out("t2_stall", 0,0,0,2'b00,1,0,0,3'd5,1);
        end
        cyc(); S_AWREADY = '1;                        exp_out("t2_addr", 1,0,0,2'b00,1,0,0,3'd5,1);
        cyc(); M00_AWVALID = 1'b0; M00_WVALID = 1'b1; exp_out("t2_data", 0,1,0,2'b00,0,1,0,3'd5,1);
        cyc(); M00_WVALID = 1'b0;                     exp_out("t2_bwait", 0,0,0,2'b00,0,0,1,3'd5,1);
        cyc();                                        exp_out("t2_bwait", 0,0,0,2'b00,0,0,1,3'd5,1);
        cyc(); S_BVALID = '1;                         exp_out("t2_resp", 0,0,1,2'b10,0,0,1,3'd5,1);
        cyc();                                        exp_out("t2_done", 0,0,0,2'b00,0,0,0,3'd5,0);

        // idx 7: local DECERR, BREADY held off two cycles
        M00_AWADDR = 32'h0000_7000; M00_AWVALID = 1'b1; M00_BREADY = 1'b0;
        exp_out("t3_idle", 0,0,0,2'b00,0,0,0,3'd5,0);
        cyc();                                        exp_out("t3_eaddr", 1,0,0,2'b00,0,0,0,3'd5,1);
        cyc(); M00_AWVALID = 1'b0; M00_WVALID = 1'b1; exp_out("t3_edata", 0,1,0,2'b00,0,0,0,3'd5,1);
        cyc(); M00_WVALID = 1'b0;                     exp_out("t3_eresp", 0,0,1,2'b11,0,0,0,3'd5,1);
        cyc();                                        exp_out("t3_hold", 0,0,1,2'b11,0,0,0,3'd5,1);
        cyc(); M00_BREADY = 1'b1;                     exp_out("t3_eresp_b", 0,0,1,2'b11,0,0,0,3'd5,1);
        cyc();                                        exp_out("t3_done", 0,0,0,2'b00,0,0,0,3'd5,0);

        // idx 1 with WVALID raised together with AWVALID and held
        whs0 = whs;
        M00_AWADDR = 32'h0000_1000; M00_AWVALID = 1'b1; M00_WVALID = 1'b1;
        exp_out("t4_idle", 0,0,0,2'b00,0,0,0,3'd5,0);
        cyc();                                        exp_out("t4_addr", 1,0,0,2'b00,1,0,0,3'd1,1);
        cyc(); M00_AWVALID = 1'b0;                    exp_out("t4_data", 0,1,0,2'b00,0,1,0,3'd1,1);
        cyc();                                        exp_out("t4_resp", 0,0,1,2'b10,0,0,1,3'd1,1);
        cyc(); M00_WVALID = 1'b0;                     exp_out("t4_done", 0,0,0,2'b00,0,0,0,3'd1,0);
        chk("t4_w_hs", whs - whs0, 32'd1);

        // back-to-back idx 0 then idx 4, second AW presented during first RESP
        M00_AWADDR = 32'h0000_0000; M00_AWVALID = 1'b1;
        exp_out("t5_idle", 0,0,0,2'b00,0,0,0,3'd1,0);
        cyc();                                        exp_out("t5_addr0", 1,0,0,2'b00,1,0,0,3'd0,1);
        cyc(); M00_AWVALID = 1'b0; M00_WVALID = 1'b1; exp_out("t5_data0", 0,1,0,2'b00,0,1,0,3'd0,1);
        cyc(); M00_WVALID = 1'b0; M00_AWADDR = 32'h0000_4000; M00_AWVALID = 1'b1;
                                                      exp_out("t5_resp0", 0,0,1,2'b00,0,0,1,3'd0,1);
        cyc();                                        exp_out("t5_idle2", 0,0,0,2'b00,0,0,0,3'd0,0);
        cyc();                                        exp_out("t5_addr4", 1,0,0,2'b00,1,0,0,3'd4,1);
        cyc(); M00_AWVALID = 1'b0; M00_WVALID = 1'b1; exp_out("t5_data4", 0,1,0,2'b00,0,1,0,3'd4,1);
        cyc(); M00_WVALID = 1'b0;                     exp_out("t5_resp4", 0,0,1,2'b01,0,0,1,3'd4,1);
        cyc();                                        exp_out("t5_done", 0,0,0,2'b00,0,0,0,3'd4,0);

        // idx 2 stalled in RESP, then 3-cycle reset with live inputs
        S_BVALID = '0;
        M00_AWADDR = 32'h0000_2000; M00_AWVALID = 1'b1;
        cyc();                                        exp_out("t6_addr", 1,0,0,2'b00,1,0,0,3'd2,1);
        cyc(); M00_AWVALID = 1'b0; M00_WVALID = 1'b1; exp_out("t6_data", 0,1,0,2'b00,0,1,0,3'd2,1);
        cyc(); M00_WVALID = 1'b0;                     exp_out("t6_resp", 0,0,0,2'b00,0,0,1,3'd2,1);
        ARESET = 1'b1; S_BVALID = '1; M00_AWVALID = 1'b1; M00_WVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); exp_out("t6_rst", 0,0,0,2'b00,0,0,0,3'd0,0);
        end
        ARESET = 1'b0; M00_AWVALID = 1'b0; M00_WVALID = 1'b0;
        cyc();                                        exp_out("t6_after", 0,0,0,2'b00,0,0,0,3'd0,0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
